// File: rtl/ks_control_unit_pkg.sv
// Shared types for the K&S control unit: the instruction decode that data_path
// presents to the sequencer.
package ks_control_unit_pkg;

  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;

endpackage

// File: rtl/ks_control_unit.sv
// Multi-cycle sequencer for the K&S data_path: fetch, decode, execute and
// branch resolution, with run/halt control and a retired-instruction counter.
module ks_control_unit
  import ks_control_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halted,
  output logic [CNT_W-1:0]        instr_count
);

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    DECODE   = 3'd1,
    EXEC_LD  = 3'd2,
    EXEC_ST  = 3'd3,
    EXEC_ALU = 3'd4,
    EXEC_BR  = 3'd5,
    HALT     = 3'd6
  } state_t;

  state_t     state;
  logic [1:0] alu_op;
  logic       alu_flags;
  logic       unused_signed_overflow;

  // No branch condition tests signed overflow; the flag is accepted for
  // interface completeness only.
  assign unused_signed_overflow = signed_overflow;

  function automatic logic branch_taken(input decoded_instruction_type ins,
                                        input logic z, input logic n,
                                        input logic c);
    logic taken;
    taken = 1'b0;
    case (ins)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = z;
      I_BNZERO: taken = ~z;
      I_BNEG:   taken = n;
      I_BNNEG:  taken = ~n;
      I_BOV:    taken = c;
      I_BNOV:   taken = ~c;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

  // ALU operation and flag-enable are captured at DECODE so EXEC_ALU drives
  // them from state alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      instr_count <= '0;
      alu_op      <= 2'b00;
      alu_flags   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (run) state <= DECODE;
        end
        DECODE: begin
          case (decoded_instruction)
            I_LOAD:  state <= EXEC_LD;
            I_STORE: state <= EXEC_ST;
            I_ADD: begin
              state     <= EXEC_ALU;
              alu_op    <= 2'b00;
              alu_flags <= 1'b1;
            end
            I_AND: begin
              state     <= EXEC_ALU;
              alu_op    <= 2'b01;
              alu_flags <= 1'b1;
            end
            I_OR: begin
              state     <= EXEC_ALU;
              alu_op    <= 2'b10;
              alu_flags <= 1'b1;
            end
            I_SUB: begin
              state     <= EXEC_ALU;
              alu_op    <= 2'b11;
              alu_flags <= 1'b1;
            end
            I_MOVE: begin
              state     <= EXEC_ALU;
              alu_op    <= 2'b10;
              alu_flags <= 1'b0;
            end
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
              state <= EXEC_BR;
            I_HALT: begin
              state       <= HALT;
              instr_count <= instr_count + CNT_W'(1);
            end
            default: begin
              state       <= FETCH;
              instr_count <= instr_count + CNT_W'(1);
            end
          endcase
        end
        EXEC_LD, EXEC_ST, EXEC_ALU, EXEC_BR: begin
          state       <= FETCH;
          instr_count <= instr_count + CNT_W'(1);
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs decode the current state; run and the flags are sampled in the
  // same cycle they act on. A reset cycle looks like an idle FETCH.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b1;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halted           = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          if (run) begin
            ir_enable = 1'b1;
            pc_enable = 1'b1;
          end
        end
        EXEC_LD: begin
          addr_sel         = 1'b0;
          c_sel            = 1'b1;
          write_reg_enable = 1'b1;
        end
        EXEC_ST: begin
          addr_sel         = 1'b0;
          ram_write_enable = 1'b1;
        end
        EXEC_ALU: begin
          write_reg_enable = 1'b1;
          operation        = alu_op;
          flags_reg_enable = alu_flags;
        end
        EXEC_BR: begin
          addr_sel = 1'b0;
          if (branch_taken(decoded_instruction, zero_op, neg_op,
                           unsigned_overflow)) begin
            pc_enable = 1'b1;
            branch    = 1'b1;
          end
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ks_control_unit.sv
// Self-checking bench for ks_control_unit: directed scenarios plus a random
// instruction stream checked against an instruction-level reference model.
module tb_ks_control_unit;
  import ks_control_unit_pkg::*;

  localparam int CNT_W = 16;

  // Observed/expected output bundle: branch, pc_enable, ir_enable, addr_sel,
  // c_sel, operation, write_reg_enable, flags_reg_enable, ram_write_enable, halted
  typedef struct packed {
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       wre;
    logic       fre;
    logic       rwe;
    logic       halted;
  } outs_t;

  localparam outs_t IDLE_V  = 11'b000_1_0_00_0_0_0_0;
  localparam outs_t FETCH_V = 11'b011_1_0_00_0_0_0_0;
  localparam outs_t HALT_V  = 11'b000_1_0_00_0_0_0_1;

  logic                    clk;
  logic                    rst;
  logic                    run;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  logic                    ram_write_enable;
  logic                    halted;
  logic [CNT_W-1:0]        instr_count;
  logic [3:0]              small_count;
  logic [10:0]             small_unused;

  int          total;
  int          bad;
  logic [31:0] retired;

  ks_control_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run),
    .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .ram_write_enable(ram_write_enable), .halted(halted),
    .instr_count(instr_count)
  );

  // Narrow-counter instance sharing all stimulus, so wrap-around is reachable.
  ks_control_unit #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .run(run),
    .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op),
    .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .branch(small_unused[0]), .pc_enable(small_unused[1]),
    .ir_enable(small_unused[2]), .addr_sel(small_unused[3]),
    .c_sel(small_unused[4]), .operation(small_unused[6:5]),
    .write_reg_enable(small_unused[7]), .flags_reg_enable(small_unused[8]),
    .ram_write_enable(small_unused[9]), .halted(small_unused[10]),
    .instr_count(small_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t observe();
    return {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
            write_reg_enable, flags_reg_enable, ram_write_enable, halted};
  endfunction

  // Reference model: instructions with a distinct execute cycle.
  function automatic bit model_has_exec(input decoded_instruction_type ins);
    return ins inside {I_LOAD, I_STORE, I_ADD, I_SUB, I_AND, I_OR, I_MOVE,
                       I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG,
                       I_BOV, I_BNOV};
  endfunction

  // Reference model: expected outputs during the execute cycle, given the
  // flags {zero, neg, carry} present in that cycle.
  function automatic outs_t model_exec(input decoded_instruction_type ins,
                                       input logic [2:0] fl);
    outs_t o;
    bit    taken;
    o     = IDLE_V;
    taken = 1'b0;
    case (ins)
      I_LOAD:  begin o.addr_sel = 1'b0; o.c_sel = 1'b1; o.wre = 1'b1; end
      I_STORE: begin o.addr_sel = 1'b0; o.rwe = 1'b1; end
      I_ADD:   begin o.wre = 1'b1; o.fre = 1'b1; o.operation = 2'b00; end
      I_AND:   begin o.wre = 1'b1; o.fre = 1'b1; o.operation = 2'b01; end
      I_OR:    begin o.wre = 1'b1; o.fre = 1'b1; o.operation = 2'b10; end
      I_SUB:   begin o.wre = 1'b1; o.fre = 1'b1; o.operation = 2'b11; end
      I_MOVE:  begin o.wre = 1'b1; o.operation = 2'b10; end
      default: ;
    endcase
    if (ins inside {I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV}) begin
      case (ins)
        I_BRANCH: taken = 1'b1;
        I_BZERO:  taken = fl[2];
        I_BNZERO: taken = !fl[2];
        I_BNEG:   taken = fl[1];
        I_BNNEG:  taken = !fl[1];
        I_BOV:    taken = fl[0];
        default:  taken = !fl[0];
      endcase
      o.addr_sel = 1'b0;
      o.pc_enable = taken;
      o.branch    = taken;
    end
    return o;
  endfunction

  // Drives one instruction from a FETCH cycle and captures the outputs of each
  // cycle it occupies; ends one step after the edge that leaves it.
  task automatic run_instr(input decoded_instruction_type ins,
                           input logic [2:0] dflags, input logic [2:0] eflags,
                           output outs_t f, output outs_t d, output outs_t e);
    run = 1'b1;
    #1; f = observe();
    @(posedge clk); #1;
    decoded_instruction = ins;
    {zero_op, neg_op, unsigned_overflow} = dflags;
    #1; d = observe();
    @(posedge clk); #1;
    e = IDLE_V;
    if (model_has_exec(ins)) begin
      {zero_op, neg_op, unsigned_overflow} = eflags;
      #1; e = observe();
      @(posedge clk); #1;
    end
    retired = retired + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (observe() !== IDLE_V) begin
        bad++; $display("[TB] FAIL reset_outputs: got %b want %b", observe(), IDLE_V);
      end
    end
    rst = 1'b0; retired = 0;
    #1;
    total++;
    if (observe() !== FETCH_V) begin
      bad++; $display("[TB] FAIL reset_release_fetch: got %b want %b", observe(), FETCH_V);
    end
    total++;
    if (instr_count !== 16'd0 || halted !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_release_count: got %h/%b want 0000/0", instr_count, halted);
    end
  endtask

  task automatic test_load_add();
    outs_t f, d, e;
    run_instr(I_LOAD, 3'b000, 3'b000, f, d, e);
    total++;
    if (e !== model_exec(I_LOAD, 3'b000)) begin
      bad++; $display("[TB] FAIL load_exec: got %b want %b", e, model_exec(I_LOAD, 3'b000));
    end
    run_instr(I_ADD, 3'b000, 3'b000, f, d, e);
    total++;
    if (f !== FETCH_V || d !== IDLE_V) begin
      bad++; $display("[TB] FAIL add_fetch_decode: got %b/%b want %b/%b", f, d, FETCH_V, IDLE_V);
    end
    total++;
    if (e !== model_exec(I_ADD, 3'b000)) begin
      bad++; $display("[TB] FAIL add_exec: got %b want %b", e, model_exec(I_ADD, 3'b000));
    end
    total++;
    if (instr_count !== 16'd2) begin
      bad++; $display("[TB] FAIL load_add_count: got %0d want 2", instr_count);
    end
  endtask

  task automatic test_branch();
    outs_t f, d, e;
    run_instr(I_BZERO, 3'b100, 3'b100, f, d, e);
    total++;
    if (e !== 11'b110_0_0_00_0_0_0_0) begin
      bad++; $display("[TB] FAIL bzero_taken: got %b want %b", e, 11'b11000000000);
    end
    run_instr(I_BZERO, 3'b000, 3'b000, f, d, e);
    total++;
    if (e !== 11'b000_0_0_00_0_0_0_0) begin
      bad++; $display("[TB] FAIL bzero_not_taken: got %b want %b", e, 11'b0);
    end
  endtask

  task automatic test_move_after_sub();
    outs_t f, d, e;
    run_instr(I_SUB, 3'b010, 3'b010, f, d, e);
    total++;
    if (e !== model_exec(I_SUB, 3'b010)) begin
      bad++; $display("[TB] FAIL sub_exec: got %b want %b", e, model_exec(I_SUB, 3'b010));
    end
    run_instr(I_MOVE, 3'b010, 3'b010, f, d, e);
    total++;
    if (e.operation !== 2'b10 || e.wre !== 1'b1 || e.fre !== 1'b0) begin
      bad++; $display("[TB] FAIL move_exec: got op=%b wre=%b fre=%b want op=10 wre=1 fre=0",
                      e.operation, e.wre, e.fre);
    end
  endtask

  task automatic test_run_pause();
    run = 1'b1; #1;
    total++;
    if (observe() !== FETCH_V) begin
      bad++; $display("[TB] FAIL pause_fetch: got %b want %b", observe(), FETCH_V);
    end
    @(posedge clk); #1;
    decoded_instruction = I_ADD; run = 1'b0; #1;
    total++;
    if (observe() !== IDLE_V) begin
      bad++; $display("[TB] FAIL pause_decode: got %b want %b", observe(), IDLE_V);
    end
    @(posedge clk); #2;
    total++;
    if (observe() !== model_exec(I_ADD, 3'b000)) begin
      bad++; $display("[TB] FAIL pause_exec_add: got %b want %b", observe(), model_exec(I_ADD, 3'b000));
    end
    @(posedge clk); #1;
    retired = retired + 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (observe() !== IDLE_V || instr_count !== retired[CNT_W-1:0]) begin
        bad++; $display("[TB] FAIL pause_hold: got %b cnt=%0d want %b cnt=%0d",
                        observe(), instr_count, IDLE_V, retired[CNT_W-1:0]);
      end
      @(posedge clk); #1;
    end
    run = 1'b1; #1;
    total++;
    if (observe() !== FETCH_V) begin
      bad++; $display("[TB] FAIL pause_resume: got %b want %b", observe(), FETCH_V);
    end
    @(posedge clk); #1;
    run = 1'b0; decoded_instruction = I_SUB;
    @(posedge clk); #2;
    total++;
    if (observe() !== model_exec(I_SUB, 3'b000)) begin
      bad++; $display("[TB] FAIL pause_resume_exec: got %b want %b", observe(), model_exec(I_SUB, 3'b000));
    end
    @(posedge clk); #1;
    retired = retired + 1;
  endtask

  task automatic test_random();
    outs_t f, d, e;
    decoded_instruction_type ins;
    logic [4:0] v;
    logic [2:0] dfl, efl;
    for (int n = 0; n < 150; n++) begin
      v = 5'($urandom_range(0, 19));
      if (v >= 5'd15) v = v + 5'd2;
      ins = decoded_instruction_type'(v);
      dfl = 3'($urandom_range(0, 7));
      efl = 3'($urandom_range(0, 7));
      run_instr(ins, dfl, efl, f, d, e);
      total++;
      if (f !== FETCH_V || d !== IDLE_V) begin
        bad++; $display("[TB] FAIL rand_fetch_decode ins=%0d: got %b/%b want %b/%b",
                        v, f, d, FETCH_V, IDLE_V);
      end
      if (model_has_exec(ins)) begin
        total++;
        if (e !== model_exec(ins, efl)) begin
          bad++; $display("[TB] FAIL rand_exec ins=%0d fl=%b: got %b want %b",
                          v, efl, e, model_exec(ins, efl));
        end
      end
      total++;
      if (instr_count !== retired[CNT_W-1:0] || small_count !== retired[3:0]) begin
        bad++; $display("[TB] FAIL rand_count: got %0d/%0d want %0d/%0d",
                        instr_count, small_count, retired[CNT_W-1:0], retired[3:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    run = 1'b1;
    @(posedge clk); #1;
    decoded_instruction = I_LOAD;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    total++;
    if (observe() !== IDLE_V) begin
      bad++; $display("[TB] FAIL reset_mid_outputs: got %b want %b", observe(), IDLE_V);
    end
    @(posedge clk); #1;
    rst = 1'b0; retired = 0; #1;
    total++;
    if (instr_count !== 16'd0 || observe() !== FETCH_V) begin
      bad++; $display("[TB] FAIL reset_mid_recover: got cnt=%0d %b want cnt=0 %b",
                      instr_count, observe(), FETCH_V);
    end
  endtask

  task automatic test_store_halt();
    outs_t f, d, e;
    run_instr(I_STORE, 3'b000, 3'b000, f, d, e);
    total++;
    if (e.rwe !== 1'b1 || e.wre !== 1'b0 || e !== model_exec(I_STORE, 3'b000)) begin
      bad++; $display("[TB] FAIL store_exec: got %b want %b", e, model_exec(I_STORE, 3'b000));
    end
    run_instr(I_HALT, 3'b000, 3'b000, f, d, e);
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      {zero_op, neg_op, unsigned_overflow} = 3'($urandom_range(0, 7));
      decoded_instruction = decoded_instruction_type'(5'($urandom_range(0, 15)));
      #1;
      total++;
      if (observe() !== HALT_V || instr_count !== retired[CNT_W-1:0]) begin
        bad++; $display("[TB] FAIL halt_hold: got %b cnt=%0d want %b cnt=%0d",
                        observe(), instr_count, HALT_V, retired[CNT_W-1:0]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0; retired = 0; #1;
    total++;
    if (observe() !== IDLE_V || instr_count !== 16'd0) begin
      bad++; $display("[TB] FAIL halt_reset_clear: got %b cnt=%0d want %b cnt=0",
                      observe(), instr_count, IDLE_V);
    end
  endtask

  initial begin
    total = 0; bad = 0; retired = 0;
    rst = 1'b1; run = 1'b0;
    decoded_instruction = I_NOP;
    zero_op = 1'b0; neg_op = 1'b0; unsigned_overflow = 1'b0; signed_overflow = 1'b0;
    test_reset();
    test_load_add();
    test_branch();
    test_move_after_sub();
    test_run_pause();
    test_random();
    test_reset_mid();
    test_store_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
